// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit: restoring divider and shift-add multiplier.
// Define MULDIV_FAST_MUL_EN to replace the shift-add multiply with a single-cycle product.
module muldiv_seq #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned CNT_W = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] ONES = '1;
  localparam logic [XLEN-1:0] MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q, state_d;
  logic             ready_q, valid_q;
  logic [2:0]       op_q, op_d;
  logic [XLEN-1:0]  a_q, a_d, b_q, b_d;
  logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d, dvs_q, dvs_d;
  logic [XLEN-1:0]  res_q, res_d;
  logic [TAG_W-1:0] tag_q, tag_d, otag_q, otag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  function automatic logic sgn_a(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic sgn_b(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic [XLEN-1:0] mag(input logic s, input logic [XLEN-1:0] v);
    return (s && v[XLEN-1]) ? -v : v;
  endfunction

  // Request side: operand magnitudes and single-cycle special cases
  logic            accept;
  logic            in_special;
  logic [XLEN-1:0] in_ma, in_mb;

  assign accept = in_valid && ready_q && !flush;
  assign in_ma  = mag(sgn_a(in_op), in_a);
  assign in_mb  = mag(sgn_b(in_op), in_b);
`ifdef MULDIV_FAST_MUL_EN
  assign in_special = !in_op[2] || (in_b == '0) ||
                      (sgn_b(in_op) && (in_a == MIN) && (in_b == ONES));
`else
  assign in_special = in_op[2] && ((in_b == '0) ||
                      (sgn_b(in_op) && (in_a == MIN) && (in_b == ONES)));
`endif

  // One iteration step: restoring-division subtract and shift-add accumulate
  logic [XLEN:0] shifted, diff, sum;
  assign shifted = {hi_q, lo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs_q};
  assign sum     = {1'b0, hi_q} + ({1'b0, dvs_q} & {(XLEN+1){lo_q[0]}});

  // Final sign correction and result select from the captured request
  logic              fa, fb, divz, ovf;
  logic [XLEN-1:0]   quo, rem, fin;
  logic [2*XLEN-1:0] prod_u, prod;

  assign fa   = sgn_a(op_q) && a_q[XLEN-1];
  assign fb   = sgn_b(op_q) && b_q[XLEN-1];
  assign divz = (b_q == '0);
  assign ovf  = sgn_b(op_q) && (a_q == MIN) && (b_q == ONES);
  assign quo  = divz ? ONES : ovf ? a_q : (fa ^ fb) ? -lo_q : lo_q;
  assign rem  = divz ? a_q : ovf ? '0 : fa ? -hi_q : hi_q;
`ifdef MULDIV_FAST_MUL_EN
  assign prod_u = {{XLEN{1'b0}}, mag(sgn_a(op_q), a_q)} * {{XLEN{1'b0}}, mag(sgn_b(op_q), b_q)};
`else
  assign prod_u = {hi_q, lo_q};
`endif
  assign prod = (fa ^ fb) ? -prod_u : prod_u;

  always_comb begin
    case (op_q)
      OP_MUL:           fin = prod[XLEN-1:0];
      OP_DIV, OP_DIVU:  fin = quo;
      OP_REM, 3'b111:   fin = rem;
      default:          fin = prod[2*XLEN-1:XLEN];
    endcase
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    tag_d   = tag_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    otag_d  = otag_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BUSY;
          op_d    = in_op;
          a_d     = in_a;
          b_d     = in_b;
          tag_d   = in_tag;
          hi_d    = '0;
          lo_d    = in_op[2] ? in_ma : in_mb;
          dvs_d   = in_op[2] ? in_mb : in_ma;
          cnt_d   = in_special ? CNT_W'(1) : CNT_W'(XLEN);
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (op_q[2]) begin
            hi_d = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], !diff[XLEN]};
          end else begin
            hi_d = sum[XLEN:1];
            lo_d = {sum[0], lo_q[XLEN-1:1]};
          end
        end else begin
          state_d = DONE;
          res_d   = fin;
          otag_d  = tag_q;
        end
      end
      DONE: begin
        if (valid_q && out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      otag_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == IDLE);
      valid_q <= (state_d == DONE);
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      otag_q  <= otag_d;
    end
  end

  assign in_ready   = ready_q;
  assign out_valid  = valid_q;
  assign out_result = res_q;
  assign out_tag    = otag_q;

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; SHALL be an even number of at least 8.
REQ-002 Parameter TAG_W, default 5, width of the destination tag passed through with the result.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  unit can accept; high only in IDLE.
REQ-007 in_op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 in_a, in_b  input  XLEN  rs1, rs2 operands.
REQ-009 in_tag  input  TAG_W  destination tag.
REQ-010 flush  input  1  discard the in-flight operation.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 out_result  output  XLEN  result.
REQ-014 out_tag  output  TAG_W  tag captured at acceptance.

Function
REQ-015 States IDLE, BUSY, DONE; acceptance = rising edge with in_valid & in_ready & !flush; IDLE->BUSY on acceptance.
REQ-016 Operands, op and tag SHALL be registered at acceptance; input changes afterwards SHALL have no effect.
REQ-017 Iterative path (DIV/DIVU/REM/REMU; MUL* without the fast multiplier): BUSY for exactly XLEN cycles (one quotient bit or one multiplier bit per cycle), then DONE; out_valid rises XLEN+1 edges after the acceptance edge.
REQ-018 Division SHALL use the magnitudes of the operands, with the signs corrected at the end; the quotient truncates toward zero and the remainder takes the sign of the dividend.
REQ-019 Divisor zero: quotient = all ones, remainder = in_a; this result SHALL be reached via one BUSY cycle, with out_valid rising 2 edges after acceptance.
REQ-020 Signed overflow (DIV/REM with in_a = most negative, in_b = all ones): quotient = in_a, remainder = 0; same 2-edge latency.
REQ-021 MUL returns the low XLEN bits of the product; MULH returns the high XLEN bits of signed x signed, MULHSU of signed in_a x unsigned in_b, and MULHU of unsigned x unsigned.
REQ-022 In DONE, out_valid = 1 and out_result/out_tag SHALL be held stable until out_ready; DONE->IDLE on out_valid & out_ready.
REQ-023 in_ready = 0 in BUSY and DONE; the minimum spacing between acceptances is therefore latency + 1 cycle.
REQ-024 flush in any state: the next state SHALL be IDLE and out_valid = 0 from the next edge; flush SHALL win over a simultaneous in_valid or out_ready.
REQ-025 out_result and out_tag are don't-care while out_valid = 0.

Reset
REQ-026 When rst_n = 0 at an edge: state IDLE, out_valid 0, out_result 0, out_tag 0, iteration counter 0; in_ready high from the first edge after release.
REQ-027 Reset mid-operation SHALL abandon the operation with no result emitted; reset has priority over flush and over all handshakes.

Configuration
REQ-028 Macro MULDIV_FAST_MUL_EN defined: MUL/MULH/MULHSU/MULHU SHALL use a single-cycle 2XLEN-bit product (one BUSY cycle, out_valid 2 edges after acceptance); division is unchanged.
REQ-029 Macro undefined: all multiplies SHALL use the XLEN-cycle shift-add path of REQ-017, with identical results.

Verification
REQ-030 DIV 20/5, then DIV -20/5, at XLEN=32 -> 4, then 0xFFFFFFFC; each with out_valid exactly 33 edges after acceptance; REM 20/6 -> 2; REM -20/6 -> 0xFFFFFFFE.
REQ-031 DIVU 20/0 -> 0xFFFFFFFF; REM 20/0 -> 20; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0; each at 2-edge latency.
REQ-032 MUL -6*7 -> 0xFFFFFFD6; MULH -6*7 -> 0xFFFFFFFF; MULHSU -6*7 -> 0xFFFFFFFF; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; latency is 2 edges with MULDIV_FAST_MUL_EN and 33 without.
REQ-033 Hold out_ready = 0 for 5 cycles in DONE -> out_valid, out_result and out_tag stay stable and in_ready stays 0; result drains on the first out_ready.
REQ-034 Assert flush at BUSY cycle 10 with in_valid also high -> no out_valid, IDLE next edge, no acceptance that edge; the next request completes correctly.
REQ-035 Drop rst_n mid-DIV -> all outputs at their reset values; the request after release returns the correct result; repeat at XLEN=16 with TAG_W=3 for tag passthrough.
